mem_stage_cache: RTL

Parametrised memory-stage block: sits between EX and WB, resolves branch conditions from EX flags, selects the sprite/ALU result and serves load/store through a direct-mapped, write-through, no-write-allocate cache backed by main memory over a req/ack handshake. It stalls the pipeline on a read miss or a store. Its rd_data, rd_valid and mem_ALU_WB_select outputs feed the WB mux.

---
 rtl/mem_stage_cache_pkg.sv | 42 ++++
 rtl/mem_stage_cache_if.sv | 26 ++
 rtl/mem_stage_cache_branch_eval.sv | 34 +++
 rtl/mem_stage_cache.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_cache_pkg.sv
// mem_stage_pkg: shared definitions for the memory-stage cache slice.
//   - Branch condition encodings (NEQ..UNCOND) used by branch_eval.
//   - FSM state enum for the cache controller.
//   - Geometry helpers (index/tag widths from ADDR_W and LINES).
//   - line_t: one cache line {valid, tag, data} for the default geometry,
//     for monitors and debug views that want the line as one packed value.
package mem_stage_pkg;

  localparam logic [2:0] NEQ    = 3'd0;
  localparam logic [2:0] EQ     = 3'd1;
  localparam logic [2:0] GT     = 3'd2;
  localparam logic [2:0] LT     = 3'd3;
  localparam logic [2:0] GTE    = 3'd4;
  localparam logic [2:0] LTE    = 3'd5;
  localparam logic [2:0] OVFL   = 3'd6;
  localparam logic [2:0] UNCOND = 3'd7;

  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LINES  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines);
  endfunction

  typedef struct packed {
    logic                                      valid;
    logic [tag_w(DEF_ADDR_W, DEF_LINES)-1:0]   tag;
    logic [DEF_DATA_W-1:0]                     data;
  } line_t;

endpackage

// File: rtl/mem_stage_cache_if.sv
// mem_stage_cache_if: backing-memory req/ack bus.
//   master (cache side): drives mem_req, mem_we, mem_addr, mem_wdata;
//                        receives mem_ack, mem_rdata.
//   slave  (memory side): the mirror image.
// mem_req/mem_we/mem_addr/mem_wdata hold steady until the cycle mem_ack is high.
interface mem_stage_cache_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_cache_branch_eval.sv
// branch_eval: decodes a 3-bit branch condition against EX flags.
//   cond      in  condition code (NEQ..UNCOND from mem_stage_pkg)
//   flag_ov   in  overflow flag V
//   flag_neg  in  negative flag N
//   flag_zero in  zero flag Z
//   taken     out condition satisfied (combinational)
// Also intended for reuse by fetch-stage branch prediction.
module branch_eval
  import mem_stage_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_ov,
  input  logic       flag_neg,
  input  logic       flag_zero,
  output logic       taken
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    taken = 1'b0;
    unique case (cond)
      NEQ:    taken = !flag_zero;
      EQ:     taken = flag_zero;
      GT:     taken = !flag_zero && !flag_neg;
      LT:     taken = flag_neg;
      GTE:    taken = !flag_neg;
      LTE:    taken = flag_neg || flag_zero;
      OVFL:   taken = flag_ov;
      UNCOND: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_cache.sv
// mem_stage_cache: memory stage between EX and WB.
//   - Direct-mapped, write-through, no-write-allocate cache in front of a
//     req/ack backing memory (mem port, master modport).
//   - Stalls upstream (stall) while a read miss fills or a store writes through.
//   - rd_data/rd_valid/cache_hit: registered load result, one-cycle pulse.
//   - mem_ALU_WB_select: mem_ALU_select captured with the accepted request.
//   - sprite_ALU_result: wr_data or sprite_data mux (combinational).
//   - branch_taken: branch_eval decode of branch_condition vs EX flags.
// Build option: define MEM_STAGE_CACHE_EN to include the tag/valid/data arrays.
// Without it every load goes to memory, cache_hit is 0 and flush is ignored.
module mem_stage_cache
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINES  = DEF_LINES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic [DATA_W-1:0] sprite_data,
  input  logic              sprite_ALU_select,
  input  logic              mem_ALU_select,
  input  logic              flag_ov,
  input  logic              flag_neg,
  input  logic              flag_zero,
  input  logic [2:0]        branch_condition,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              cache_hit,
  output logic [DATA_W-1:0] sprite_ALU_result,
  output logic              mem_ALU_WB_select,
  output logic              branch_taken,
  mem_stage_cache_if.master mem
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_data_q;
  logic                accept;
  logic                ack_fill;
  logic                lookup_hit;
  logic [DATA_W-1:0]   lookup_data;

  assign accept   = (state_q == IDLE) && valid_in;
  assign ack_fill = (state_q == FILL) && mem.mem_ack;
  assign stall    = (state_q != IDLE);

  assign sprite_ALU_result = sprite_ALU_select ? wr_data : sprite_data;

  branch_eval u_branch_eval (
    .cond      (branch_condition),
    .flag_ov   (flag_ov),
    .flag_neg  (flag_neg),
    .flag_zero (flag_zero),
    .taken     (branch_taken)
  );

  // Lookup uses the live request inputs so a hit is answered at the accept edge.
`ifdef MEM_STAGE_CACHE_EN
  localparam int IDX_W = index_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic              flush_seen_q;
  logic [IDX_W-1:0]  lk_idx, req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              ack_write, fill_we, write_hit_we;

  assign lk_idx      = addr[IDX_W-1:0];
  assign lookup_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == addr[ADDR_W-1:IDX_W]);
  assign lookup_data = data_q[lk_idx];

  assign req_idx   = req_addr_q[IDX_W-1:0];
  assign req_tag   = req_addr_q[ADDR_W-1:IDX_W];
  assign ack_write = (state_q == WRITE) && mem.mem_ack;
  // A flush anywhere in the fill means the returned line must not be installed.
  assign fill_we      = ack_fill && !flush && !flush_seen_q;
  // Write-through, no allocate: only refresh a line that is already resident.
  assign write_hit_we = ack_write && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      if (flush)        valid_q          <= '0;
      else if (fill_we) valid_q[req_idx] <= 1'b1;
      flush_seen_q <= (state_q == FILL) && !mem.mem_ack && (flush || flush_seen_q);
    end
  end

  // NOTE: tag/data arrays are not reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mem.mem_rdata;
    end else if (write_hit_we) begin
      data_q[req_idx] <= req_data_q;
    end
  end
`else
  logic flush_unused;
  assign flush_unused = flush;
  assign lookup_hit   = 1'b0;
  assign lookup_data  = '0;
`endif

  always_comb begin
    state_d       = state_q;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (cmd)              state_d = WRITE;
          else if (!lookup_hit) state_d = FILL;
        end
      end
      FILL: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) state_d = IDLE;
      end
      WRITE: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        if (mem.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_addr  = req_addr_q;
  assign mem.mem_wdata = req_data_q;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      req_addr_q        <= '0;
      req_data_q        <= '0;
      rd_data           <= '0;
      rd_valid          <= 1'b0;
      cache_hit         <= 1'b0;
      mem_ALU_WB_select <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_valid  <= 1'b0;
      cache_hit <= 1'b0;
      if (accept) begin
        req_addr_q        <= addr;
        req_data_q        <= wr_data;
        mem_ALU_WB_select <= mem_ALU_select;
        if (!cmd && lookup_hit) begin
          rd_data   <= lookup_data;
          rd_valid  <= 1'b1;
          cache_hit <= 1'b1;
        end
      end
      if (ack_fill) begin
        rd_data  <= mem.mem_rdata;
        rd_valid <= 1'b1;
      end
    end
  end

endmodule
